fetch_unit: RTL and testbench

- Front-end producer for the 4-wide instruction buffer interface.
- Fetches aligned groups of four 16-bit instruction words from instruction memory and decodes each word into opcode, r_a, r_b and rt.
- Presents up to four valid instructions per cycle on lanes 0..3, with a ready/valid handshake.
- Handles memory latency, back-pressure, redirects from the back end, and halt.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_group_decoder.sv | 27 ++
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam int LANES      = 4;
    localparam int WORD_W     = 16;
    localparam int OPCODE_LSB = 12;
    localparam int RT_LSB     = 8;
    localparam int RA_LSB     = 4;
    localparam int RB_LSB     = 0;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        logic [3:0] r_a;
        logic [3:0] r_b;
        logic [3:0] rt;
    } inst_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    function automatic inst_t decode_word(input logic [WORD_W-1:0] w);
        inst_t d;
        d.valid  = 1'b0;
        d.opcode = w[OPCODE_LSB +: 4];
        d.rt     = w[RT_LSB +: 4];
        d.r_a    = w[RA_LSB +: 4];
        d.r_b    = w[RB_LSB +: 4];
        return d;
    endfunction

endpackage

// File: rtl/fetch_group_decoder.sv
// rtl/fetch_group_decoder.sv - splits a fetched group into lanes, masks by offset, truncates at HALT
module fetch_group_decoder
    import fetch_pkg::*;
(
    input  logic [LANES*WORD_W-1:0] group,
    input  logic [1:0]              offset,
    output inst_t [LANES-1:0]       lanes,
    output logic                    halt_seen
);

    always_comb begin
        halt_seen = 1'b0;
        lanes     = '0;
        for (int k = 0; k < LANES; k++) begin
            lanes[k] = decode_word(group[k*WORD_W +: WORD_W]);
            // Once a HALT is found, it and every later lane stay invalid.
            if (k >= int'(offset) && !halt_seen) begin
                if (lanes[k].opcode == OP_HALT) begin
                    halt_seen = 1'b1;
                end else begin
                    lanes[k].valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - 4-wide fetch front end with output register, skid entry and redirect/halt control
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [63:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            ready,
    output logic            valid_0,
    output logic            valid_1,
    output logic            valid_2,
    output logic            valid_3,
    output logic [3:0]      opcode_0,
    output logic [3:0]      opcode_1,
    output logic [3:0]      opcode_2,
    output logic [3:0]      opcode_3,
    output logic [3:0]      rt_0,
    output logic [3:0]      rt_1,
    output logic [3:0]      rt_2,
    output logic [3:0]      rt_3,
    output logic [3:0]      r_a_0,
    output logic [3:0]      r_a_1,
    output logic [3:0]      r_a_2,
    output logic [3:0]      r_a_3,
    output logic [3:0]      r_b_0,
    output logic [3:0]      r_b_1,
    output logic [3:0]      r_b_2,
    output logic [3:0]      r_b_3,
    output logic            halted
);

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_base;
    inst_t [LANES-1:0] out_q;
    inst_t [LANES-1:0] skid_q;
    inst_t [LANES-1:0] dec;
    logic             skid_vld;
    logic             inflight;
    logic             infl_kill;
    logic [1:0]       infl_off;
    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic             out_vld;
    logic             fire;
    logic [1:0]       occ;
    logic             room;
    logic             resp;
    logic             resp_ok;
    logic             halt_seen;
    logic             halt_now;

    fetch_group_decoder u_dec (
        .group     (imem_rdata),
        .offset    (infl_off),
        .lanes     (dec),
        .halt_seen (halt_seen)
    );

    assign pc_base  = {pc[PC_W-1:2], 2'b00};
    assign out_vld  = out_q[0].valid | out_q[1].valid | out_q[2].valid | out_q[3].valid;
    assign fire     = out_vld & ready;
    assign occ      = 2'(out_vld) + 2'(skid_vld) + 2'(inflight);
    // Occupancy after this cycle's accept must stay below two groups.
    assign room     = fire ? (occ <= 2'd2) : (occ <= 2'd1);
    assign resp     = inflight & ~infl_kill;
    assign resp_ok  = resp & (dec[0].valid | dec[1].valid | dec[2].valid | dec[3].valid);
    assign halt_now = resp & halt_seen;

    assign imem_req  = run & room & ~redirect_valid & ~rst;
    assign imem_addr = pc_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
        end else if (halt_now) begin
            state_nxt = ST_HALTED;
        end
    end

    always_comb begin
        run    = (state == ST_RUN);
        halted = (state == ST_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            out_q     <= '0;
            skid_q    <= '0;
            skid_vld  <= 1'b0;
            inflight  <= 1'b0;
            infl_kill <= 1'b0;
            infl_off  <= 2'd0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            out_q     <= '0;
            skid_vld  <= 1'b0;
            inflight  <= 1'b0;
            infl_kill <= 1'b0;
        end else begin
            inflight  <= imem_req;
            // A request issued alongside a HALT response must never be presented.
            infl_kill <= halt_now;
            if (imem_req) begin
                infl_off <= pc[1:0];
                pc       <= pc_base + PC_W'(4);
            end
            if (!out_vld || fire) begin
                if (skid_vld) begin
                    out_q    <= skid_q;
                    skid_q   <= dec;
                    skid_vld <= resp_ok;
                end else begin
                    out_q <= resp_ok ? dec : '0;
                end
            end else if (resp_ok) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end
        end
    end

    assign valid_0  = out_q[0].valid;
    assign valid_1  = out_q[1].valid;
    assign valid_2  = out_q[2].valid;
    assign valid_3  = out_q[3].valid;
    assign opcode_0 = out_q[0].opcode;
    assign opcode_1 = out_q[1].opcode;
    assign opcode_2 = out_q[2].opcode;
    assign opcode_3 = out_q[3].opcode;
    assign rt_0     = out_q[0].rt;
    assign rt_1     = out_q[1].rt;
    assign rt_2     = out_q[2].rt;
    assign rt_3     = out_q[3].rt;
    assign r_a_0    = out_q[0].r_a;
    assign r_a_1    = out_q[1].r_a;
    assign r_a_2    = out_q[2].r_a;
    assign r_a_3    = out_q[3].r_a;
    assign r_b_0    = out_q[0].r_b;
    assign r_b_1    = out_q[1].r_b;
    assign r_b_2    = out_q[2].r_b;
    assign r_b_3    = out_q[3].r_b;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [63:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        ready = 1'b0;
    logic        valid_0, valid_1, valid_2, valid_3;
    logic [3:0]  opcode_0, opcode_1, opcode_2, opcode_3;
    logic [3:0]  rt_0, rt_1, rt_2, rt_3;
    logic [3:0]  r_a_0, r_a_1, r_a_2, r_a_3;
    logic [3:0]  r_b_0, r_b_1, r_b_2, r_b_3;
    logic        halted;

    logic [3:0]  vl;
    logic [3:0]  opc [4];
    logic [3:0]  rtv [4];
    logic [3:0]  rav [4];
    logic [3:0]  rbv [4];
    logic        halt_en = 1'b0;
    logic [7:0]  fq [$];
    logic [3:0]  fm [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ready(ready),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .opcode_0(opcode_0), .opcode_1(opcode_1), .opcode_2(opcode_2), .opcode_3(opcode_3),
        .rt_0(rt_0), .rt_1(rt_1), .rt_2(rt_2), .rt_3(rt_3),
        .r_a_0(r_a_0), .r_a_1(r_a_1), .r_a_2(r_a_2), .r_a_3(r_a_3),
        .r_b_0(r_b_0), .r_b_1(r_b_1), .r_b_2(r_b_2), .r_b_3(r_b_3),
        .halted(halted)
    );

    assign vl = {valid_3, valid_2, valid_1, valid_0};
    assign opc[0] = opcode_0; assign opc[1] = opcode_1; assign opc[2] = opcode_2; assign opc[3] = opcode_3;
    assign rtv[0] = rt_0;     assign rtv[1] = rt_1;     assign rtv[2] = rt_2;     assign rtv[3] = rt_3;
    assign rav[0] = r_a_0;    assign rav[1] = r_a_1;    assign rav[2] = r_a_2;    assign rav[3] = r_a_3;
    assign rbv[0] = r_b_0;    assign rbv[1] = r_b_1;    assign rbv[2] = r_b_2;    assign rbv[3] = r_b_3;

    // Words 0..3 are 16'h1234; word w>=4 is {5,0,w}; word 10 becomes HALT when halt_en is set.
    function automatic logic [15:0] mem_word(input logic [7:0] w, input logic hlt);
        if (w < 8'd4) return 16'h1234;
        if (hlt && w == 8'd10) return 16'hF000;
        return {4'h5, 4'h0, w};
    endfunction

    always @(posedge clk) begin
        if (imem_req) begin
            for (int k = 0; k < 4; k++) begin
                imem_rdata[16*k +: 16] <= mem_word(imem_addr + 8'(k), halt_en);
            end
        end
    end

    // Records each accepted bundle's group base address and lane mask.
    always @(posedge clk) begin
        if (!rst && ready && (vl != 4'b0)) begin
            for (int k = 0; k < 4; k++) begin
                if (vl[k] && (k == 0 || vl[k-1] == 1'b0)) begin
                    if (opc[k] == 4'h1) fq.push_back(8'd0);
                    else fq.push_back({rav[k], rbv[k]} - 8'(k));
                    fm.push_back(vl);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (vl !== 4'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0000", vl); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_cmp++; if (opcode_0 !== 4'h0 || r_b_3 !== 4'h0) begin n_bad++; $display("FAIL reset_fields got=%h/%h exp=0/0", opcode_0, r_b_3); end
    endtask

    task automatic test_stream();
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin n_bad++; $display("FAIL stream_req0 got=%b/%0d exp=1/0", imem_req, imem_addr); end
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd4) begin n_bad++; $display("FAIL stream_req4 got=%b/%0d exp=1/4", imem_req, imem_addr); end
        n_cmp++; if (vl !== 4'b0) begin n_bad++; $display("FAIL stream_early got=%b exp=0000", vl); end
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd8) begin n_bad++; $display("FAIL stream_req8 got=%b/%0d exp=1/8", imem_req, imem_addr); end
        n_cmp++; if (vl !== 4'hF) begin n_bad++; $display("FAIL stream_valid got=%b exp=1111", vl); end
        n_cmp++; if ({opc[0], rtv[0], rav[0], rbv[0]} !== 16'h1234) begin n_bad++; $display("FAIL stream_lane0 got=%h exp=1234", {opc[0], rtv[0], rav[0], rbv[0]}); end
        n_cmp++; if ({opc[3], rtv[3], rav[3], rbv[3]} !== 16'h1234) begin n_bad++; $display("FAIL stream_lane3 got=%h exp=1234", {opc[3], rtv[3], rav[3], rbv[3]}); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        n_cmp++; if (vl !== 4'hF || rbv[0] !== 4'd4 || rbv[3] !== 4'd7 || opc[1] !== 4'h5) begin n_bad++; $display("FAIL bp_b4 got=%b/%h/%h exp=1111/4/7", vl, rbv[0], rbv[3]); end
        n_cmp++; if (imem_addr !== 8'd12) begin n_bad++; $display("FAIL bp_addr got=%0d exp=12", imem_addr); end
        ready = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_drop got=%b exp=0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_hold%0d got=%b exp=0", i, imem_req); end
            n_cmp++; if (vl !== 4'hF || rbv[0] !== 4'd4 || rbv[2] !== 4'd6) begin n_bad++; $display("FAIL bp_stable%0d got=%b/%h exp=1111/4", i, vl, rbv[0]); end
        end
        ready = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd12) begin n_bad++; $display("FAIL bp_resume got=%b/%0d exp=1/12", imem_req, imem_addr); end
        @(negedge clk);
        n_cmp++; if (vl !== 4'hF || rbv[0] !== 4'd8) begin n_bad++; $display("FAIL bp_b8 got=%b/%h exp=1111/8", vl, rbv[0]); end
        @(negedge clk);
        n_cmp++; if (vl !== 4'hF || rbv[0] !== 4'hC) begin n_bad++; $display("FAIL bp_b12 got=%b/%h exp=1111/c", vl, rbv[0]); end
        n_cmp++; if (fq.size() != 3 || fq[0] !== 8'd0 || fq[1] !== 8'd4 || fq[2] !== 8'd8) begin n_bad++; $display("FAIL bp_order got=%p exp=0,4,8", fq); end
    endtask

    task automatic test_redirect();
        halt_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 8'd6;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_noreq got=%b exp=0", imem_req); end
        @(negedge clk);
        n_cmp++; if (vl !== 4'b0) begin n_bad++; $display("FAIL rd_flush got=%b exp=0000", vl); end
        n_cmp++; if (fq.size() != 4 || fq[3] !== 8'd12) begin n_bad++; $display("FAIL rd_fire_once got=%p exp=0,4,8,12", fq); end
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd4) begin n_bad++; $display("FAIL rd_req got=%b/%0d exp=1/4", imem_req, imem_addr); end
        @(negedge clk);
        n_cmp++; if (vl !== 4'b0 || imem_addr !== 8'd8) begin n_bad++; $display("FAIL rd_gap got=%b/%0d exp=0000/8", vl, imem_addr); end
        @(negedge clk);
        n_cmp++; if (vl !== 4'b1100 || rbv[2] !== 4'd6 || rbv[3] !== 4'd7) begin n_bad++; $display("FAIL rd_offset got=%b/%h/%h exp=1100/6/7", vl, rbv[2], rbv[3]); end
        n_cmp++; if (fq.size() != 4) begin n_bad++; $display("FAIL rd_dropped got=%0d exp=4", fq.size()); end
    endtask

    task automatic test_halt();
        @(negedge clk);
        n_cmp++; if (vl !== 4'b0011 || rbv[0] !== 4'd8 || rbv[1] !== 4'd9) begin n_bad++; $display("FAIL halt_bundle got=%b/%h/%h exp=0011/8/9", vl, rbv[0], rbv[1]); end
        n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_state got=%b/%b exp=1/0", halted, imem_req); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (vl !== 4'b0 || halted !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_idle%0d got=%b/%b/%b exp=0000/1/0", i, vl, halted, imem_req); end
        end
        n_cmp++; if (fq.size() != 6 || fq[4] !== 8'd4 || fq[5] !== 8'd8 || fm[5] !== 4'b0011) begin n_bad++; $display("FAIL halt_drained got=%p exp=..,4,8", fq); end
        halt_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'd0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_rd_noreq got=%b exp=0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'd0) begin n_bad++; $display("FAIL halt_restart got=%b/%b/%0d exp=0/1/0", halted, imem_req, imem_addr); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (vl !== 4'hF || opc[0] !== 4'h1) begin n_bad++; $display("FAIL halt_refetch got=%b/%h exp=1111/1", vl, opc[0]); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vl !== 4'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL rstmid_async got=%b/%b/%b exp=0000/0/0", vl, imem_req, halted); end
        n_cmp++; if (opcode_0 !== 4'h0) begin n_bad++; $display("FAIL rstmid_fields got=%h exp=0", opcode_0); end
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin n_bad++; $display("FAIL rstmid_req got=%b/%0d exp=1/0", imem_req, imem_addr); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (vl !== 4'hF || opc[0] !== 4'h1 || rtv[3] !== 4'h2) begin n_bad++; $display("FAIL rstmid_resume got=%b/%h/%h exp=1111/1/2", vl, opc[0], rtv[3]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
